// File: rtl/mul_pkg.sv
// mul_pkg: types and defaults shared by the iterative multiply and divide cores.
package mul_pkg;
  localparam int DEFAULT_WIDTH = 32;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/iterative_multiplier.sv
// iterative_multiplier: unsigned shift-and-add multiplier, one multiplier bit per clock.
module iterative_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q, acc_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     sum;
  logic               accept, last;
  assign accept = i_start && state_q != RUN;
  assign last   = state_q == RUN && cnt_q == CNT_W'(WIDTH - 1);
  // The upper add keeps its carry so the shifted-in MSB is exact.
  always_comb begin
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_nxt = {sum, acc_q[WIDTH-1:1]};
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end
  always_comb begin
    state_d = accept ? RUN : state_q == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_comb begin
    o_busy = state_q == RUN;
    o_done = state_q == DONE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      o_product <= '0;
    end else if (accept) begin
      mcand_q <= i_multiplicand;
      acc_q   <= {{WIDTH{1'b0}}, i_multiplier};
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      acc_q <= acc_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (last) o_product <= acc_nxt;
    end
  end
endmodule
